// File: rtl/if_id_skid_stage.sv
// +--------------------------------------------------------------------------+
// | if_id_skid_stage                                                         |
// | IF/ID pipeline register with a 2-entry skid buffer and registered ready. |
// | Optional: IF_ID_PERF_CNT_EN adds saturating stall/flush counters.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module if_id_skid_stage #(
   parameter int                   PC_W      = 32,
   parameter int                   INSTR_W   = 32,
   parameter int                   META_W    = 1,
   parameter logic [INSTR_W-1:0]   NOP_INSTR = INSTR_W'(32'h0000_0033)
`ifdef IF_ID_PERF_CNT_EN
   ,
   parameter int                   CNT_W     = 16
`endif
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [PC_W-1:0]      in_pc_i,
   input  logic [INSTR_W-1:0]   in_instr_i,
   input  logic [META_W-1:0]    in_meta_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [PC_W-1:0]      out_pc_o,
   output logic [INSTR_W-1:0]   out_instr_o,
   output logic [META_W-1:0]    out_meta_o
`ifdef IF_ID_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]     stall_cnt_o,
   output logic [CNT_W-1:0]     flush_cnt_o
`endif
);

   logic                 main_valid_q, main_valid_d;
   logic [PC_W-1:0]      main_pc_q,    main_pc_d;
   logic [INSTR_W-1:0]   main_instr_q, main_instr_d;
   logic [META_W-1:0]    main_meta_q,  main_meta_d;
   logic                 skid_valid_q, skid_valid_d;
   logic [PC_W-1:0]      skid_pc_q,    skid_pc_d;
   logic [INSTR_W-1:0]   skid_instr_q, skid_instr_d;
   logic [META_W-1:0]    skid_meta_q,  skid_meta_d;
   logic                 ready_q,      ready_d;
   logic                 in_xfer;
   logic                 out_xfer;

   assign in_ready_o  = ready_q & ~rst;
   assign in_xfer     = in_valid_i & in_ready_o;
   assign out_xfer    = main_valid_q & out_ready_i;

   assign out_valid_o = main_valid_q;
   assign out_pc_o    = main_pc_q;
   assign out_instr_o = main_instr_q;
   assign out_meta_o  = main_meta_q;

   // main_instr_q is reloaded with NOP whenever main goes empty so out_instr
   // stays a pure flop output; pc/meta deliberately keep their stale values.
   always_comb begin
      main_valid_d = main_valid_q;
      main_pc_d    = main_pc_q;
      main_instr_d = main_instr_q;
      main_meta_d  = main_meta_q;
      skid_valid_d = skid_valid_q;
      skid_pc_d    = skid_pc_q;
      skid_instr_d = skid_instr_q;
      skid_meta_d  = skid_meta_q;

      if (flush_i) begin
         main_valid_d = 1'b0;
         main_instr_d = NOP_INSTR;
         skid_valid_d = 1'b0;
      end else if (!main_valid_q || out_xfer) begin
         if (skid_valid_q) begin
            main_valid_d = 1'b1;
            main_pc_d    = skid_pc_q;
            main_instr_d = skid_instr_q;
            main_meta_d  = skid_meta_q;
            skid_valid_d = in_xfer;
            if (in_xfer) begin
               skid_pc_d    = in_pc_i;
               skid_instr_d = in_instr_i;
               skid_meta_d  = in_meta_i;
            end
         end else if (in_xfer) begin
            main_valid_d = 1'b1;
            main_pc_d    = in_pc_i;
            main_instr_d = in_instr_i;
            main_meta_d  = in_meta_i;
         end else begin
            main_valid_d = 1'b0;
            main_instr_d = NOP_INSTR;
         end
      end else if (in_xfer) begin
         skid_valid_d = 1'b1;
         skid_pc_d    = in_pc_i;
         skid_instr_d = in_instr_i;
         skid_meta_d  = in_meta_i;
      end

      ready_d = ~skid_valid_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid_q <= 1'b0;
         main_pc_q    <= '0;
         main_instr_q <= NOP_INSTR;
         main_meta_q  <= '0;
         skid_valid_q <= 1'b0;
         skid_pc_q    <= '0;
         skid_instr_q <= NOP_INSTR;
         skid_meta_q  <= '0;
         ready_q      <= 1'b1;
      end else begin
         main_valid_q <= main_valid_d;
         main_pc_q    <= main_pc_d;
         main_instr_q <= main_instr_d;
         main_meta_q  <= main_meta_d;
         skid_valid_q <= skid_valid_d;
         skid_pc_q    <= skid_pc_d;
         skid_instr_q <= skid_instr_d;
         skid_meta_q  <= skid_meta_d;
         ready_q      <= ready_d;
      end
   end

`ifdef IF_ID_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;

   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (main_valid_q && !out_ready_i && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (flush_i && (main_valid_q || skid_valid_q) && (flush_cnt_q != '1))
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_id_skid_stage.sv
// +--------------------------------------------------------------------------+
// | tb_if_id_skid_stage                                                      |
// | Scoreboard bench for if_id_skid_stage (define IF_ID_PERF_CNT_EN for cnt). |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_if_id_skid_stage;

   localparam logic [31:0] NOP = 32'h0000_0033;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        meta;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [31:0] in_instr;
   logic        in_meta;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        out_meta;
`ifdef IF_ID_PERF_CNT_EN
   logic [3:0]  stall_cnt;
   logic [3:0]  flush_cnt;
`endif

   int    n_vec = 0;
   int    n_err = 0;
   beat_t sb[$];

   always #5 clk = ~clk;

   if_id_skid_stage #(
      .PC_W      (32),
      .INSTR_W   (32),
      .META_W    (1),
      .NOP_INSTR (NOP)
`ifdef IF_ID_PERF_CNT_EN
      ,
      .CNT_W     (4)
`endif
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (flush),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_pc_i     (in_pc),
      .in_instr_i  (in_instr),
      .in_meta_i   (in_meta),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_pc_o    (out_pc),
      .out_instr_o (out_instr),
      .out_meta_o  (out_meta)
`ifdef IF_ID_PERF_CNT_EN
      ,
      .stall_cnt_o (stall_cnt),
      .flush_cnt_o (flush_cnt)
`endif
   );

   // Scoreboard: accepted beats are pushed, decode-side transfers pop and compare.
   always @(negedge clk) begin
      beat_t e;
      if (rst) begin
         sb.delete();
      end else begin
         if (out_valid && out_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL sb_unexpected: got pc=%h instr=%h, required no output", out_pc, out_instr);
            end else begin
               e = sb.pop_front();
               if ({out_pc, out_instr, out_meta} !== {e.pc, e.instr, e.meta}) begin
                  n_err++;
                  $display("FAIL sb_beat: got pc=%h instr=%h meta=%b, required pc=%h instr=%h meta=%b",
                           out_pc, out_instr, out_meta, e.pc, e.instr, e.meta);
               end
            end
         end
         if (flush)
            sb.delete();
         else if (in_valid && in_ready)
            sb.push_back('{pc: in_pc, instr: in_instr, meta: in_meta});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc);
      in_valid = v;
      in_pc    = pc;
      in_instr = pc ^ 32'h00A0_0013;
      in_meta  = pc[3];
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
      drive(1'b1, 32'h999);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_vec++;
         if (in_ready !== 1'b0) begin
            n_err++; $display("FAIL rst_in_ready: got %b, required 0", in_ready);
         end
         tick();
      end
      rst = 1'b0;
      drive(1'b0, 32'h0);
      @(negedge clk);
      n_vec++;
      if ({out_valid, out_pc, out_instr, out_meta, in_ready} !== {1'b0, 32'h0, NOP, 1'b0, 1'b1}) begin
         n_err++;
         $display("FAIL post_reset: got v=%b pc=%h instr=%h meta=%b rdy=%b, required v=0 pc=0 instr=%h meta=0 rdy=1",
                  out_valid, out_pc, out_instr, out_meta, in_ready, NOP);
      end
   endtask

   task automatic test_streaming();
      logic [31:0] pcs [3];
      pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108;
      tick();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, pcs[i]);
         @(negedge clk);
         if (i > 0) begin
            n_vec++;
            if ({out_valid, out_pc} !== {1'b1, pcs[i-1]}) begin
               n_err++; $display("FAIL stream_%0d: got v=%b pc=%h, required v=1 pc=%h", i, out_valid, out_pc, pcs[i-1]);
            end
         end
         tick();
      end
      drive(1'b0, 32'h0);
      @(negedge clk);
      n_vec++;
      if ({out_valid, out_pc} !== {1'b1, 32'h108}) begin
         n_err++; $display("FAIL stream_last: got v=%b pc=%h, required v=1 pc=108", out_valid, out_pc);
      end
      tick();
      @(negedge clk);
      n_vec++;
      if ({out_valid, out_instr} !== {1'b0, NOP}) begin
         n_err++; $display("FAIL stream_empty: got v=%b instr=%h, required v=0 instr=%h", out_valid, out_instr, NOP);
      end
   endtask

   task automatic test_backpressure();
      tick();
      out_ready = 1'b1;
      drive(1'b1, 32'h100);
      tick();
      out_ready = 1'b0;
      drive(1'b1, 32'h104);
      @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_err++; $display("FAIL bp_ready_before: got %b, required 1", in_ready);
      end
      tick();
      drive(1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_vec++;
         if ({in_ready, out_valid, out_pc} !== {1'b0, 1'b1, 32'h100}) begin
            n_err++; $display("FAIL bp_stall_%0d: got rdy=%b v=%b pc=%h, required rdy=0 v=1 pc=100", i, in_ready, out_valid, out_pc);
         end
         tick();
      end
      out_ready = 1'b1;
      @(negedge clk);
      tick();
      @(negedge clk);
      n_vec++;
      if ({in_ready, out_valid, out_pc} !== {1'b1, 1'b1, 32'h104}) begin
         n_err++; $display("FAIL bp_drain: got rdy=%b v=%b pc=%h, required rdy=1 v=1 pc=104", in_ready, out_valid, out_pc);
      end
      tick();
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      drive(1'b1, 32'h180);
      tick();
      drive(1'b1, 32'h184);
      tick();
      drive(1'b0, 32'h0);
      @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b0) begin
         n_err++; $display("FAIL flush_full_ready: got %b, required 0", in_ready);
      end
      flush = 1'b1;
      drive(1'b1, 32'h200);
      tick();
      flush = 1'b0;
      drive(1'b0, 32'h0);
      @(negedge clk);
      n_vec++;
      if ({out_valid, out_instr, in_ready, out_pc} !== {1'b0, NOP, 1'b1, 32'h180}) begin
         n_err++; $display("FAIL flush_full: got v=%b instr=%h rdy=%b pc=%h, required v=0 instr=%h rdy=1 pc=180",
                           out_valid, out_instr, in_ready, out_pc, NOP);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         @(negedge clk);
         n_vec++;
         if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL flush_no_leak_%0d: got v=%b pc=%h, required v=0", i, out_valid, out_pc);
         end
      end
      tick();
      flush = 1'b1;
      drive(1'b1, 32'h204);
      tick();
      flush = 1'b0;
      drive(1'b0, 32'h0);
      @(negedge clk);
      n_vec++;
      if ({out_valid, out_pc} !== {1'b0, 32'h180}) begin
         n_err++; $display("FAIL flush_in_xfer: got v=%b pc=%h, required v=0 pc=180", out_valid, out_pc);
      end
      drive(1'b1, 32'h208);
      tick();
      drive(1'b0, 32'h0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({out_valid, out_pc, out_instr} !== {1'b0, 32'h208, NOP}) begin
         n_err++; $display("FAIL flush_out_xfer: got v=%b pc=%h instr=%h, required v=0 pc=208 instr=%h",
                           out_valid, out_pc, out_instr, NOP);
      end
   endtask

   task automatic test_reset_mid_stall();
      tick();
      out_ready = 1'b0;
      drive(1'b1, 32'h280);
      tick();
      drive(1'b1, 32'h284);
      tick();
      drive(1'b0, 32'h0);
      rst = 1'b1;
      @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b0) begin
         n_err++; $display("FAIL rst_stall_ready: got %b, required 0", in_ready);
      end
      tick();
      rst = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({out_valid, out_pc, out_instr, out_meta, in_ready} !== {1'b0, 32'h0, NOP, 1'b0, 1'b1}) begin
         n_err++; $display("FAIL rst_stall_state: got v=%b pc=%h instr=%h meta=%b rdy=%b, required v=0 pc=0 instr=%h meta=0 rdy=1",
                           out_valid, out_pc, out_instr, out_meta, in_ready, NOP);
      end
      out_ready = 1'b1;
      drive(1'b1, 32'h300);
      tick();
      drive(1'b0, 32'h0);
      @(negedge clk);
      n_vec++;
      if ({out_valid, out_pc} !== {1'b1, 32'h300}) begin
         n_err++; $display("FAIL rst_stall_next: got v=%b pc=%h, required v=1 pc=300", out_valid, out_pc);
      end
      tick();
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0) begin
         n_err++; $display("FAIL rst_stall_alone: got v=%b pc=%h, required v=0", out_valid, out_pc);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] pc = 32'h1000;
      logic        was_stall = 1'b0;
      beat_t       held;
      for (int i = 0; i < 400; i++) begin
         tick();
         drive(1'($urandom_range(0, 3) != 0), pc);
         pc        = pc + 32'd4;
         out_ready = 1'($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 40) == 0);
         @(negedge clk);
         if (was_stall) begin
            n_vec++;
            if ({out_valid, out_pc, out_instr, out_meta} !== {1'b1, held.pc, held.instr, held.meta}) begin
               n_err++; $display("FAIL stall_stable: got v=%b pc=%h instr=%h, required v=1 pc=%h instr=%h",
                                 out_valid, out_pc, out_instr, held.pc, held.instr);
            end
         end
         if (!out_valid) begin
            n_vec++;
            if (out_instr !== NOP) begin
               n_err++; $display("FAIL empty_nop: got %h, required %h", out_instr, NOP);
            end
         end
         was_stall = out_valid && !out_ready && !flush;
         held      = '{pc: out_pc, instr: out_instr, meta: out_meta};
      end
      tick();
      flush = 1'b0;
      drive(1'b0, 32'h0);
      out_ready = 1'b1;
      repeat (4) tick();
      @(negedge clk);
      n_vec++;
      if (sb.size() != 0 || out_valid !== 1'b0) begin
         n_err++; $display("FAIL drain: got %0d pending v=%b, required 0 pending v=0", sb.size(), out_valid);
      end
   endtask

`ifdef IF_ID_PERF_CNT_EN
   task automatic test_perf_cnt();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      out_ready = 1'b0;
      drive(1'b1, 32'h400);
      tick();
      drive(1'b0, 32'h0);
      repeat (20) tick();
      @(negedge clk);
      n_vec++;
      if ({stall_cnt, flush_cnt} !== {4'd15, 4'd0}) begin
         n_err++; $display("FAIL stall_cnt_sat: got stall=%0d flush=%0d, required stall=15 flush=0", stall_cnt, flush_cnt);
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      drive(1'b1, 32'h404);
      tick();
      drive(1'b0, 32'h0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({stall_cnt, flush_cnt} !== {4'd15, 4'd2}) begin
         n_err++; $display("FAIL flush_cnt: got stall=%0d flush=%0d, required stall=15 flush=2", stall_cnt, flush_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush();
      test_reset_mid_stall();
      test_back_to_back();
`ifdef IF_ID_PERF_CNT_EN
      test_perf_cnt();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
